// File: rtl/fact_pkg.sv
// fact_pkg: shared widths, range limit and FSM state type for the factorial engine.
package fact_pkg;
    localparam int N_W = 32;
    localparam int RES_W = 64;
    localparam logic [N_W-1:0] MAX_N = 20;
    localparam logic [RES_W-1:0] FACT_ONE = 64'd1;
    typedef enum logic [1:0] {IDLE, MULT, DONE} fact_state_t;
endpackage

// File: rtl/factorial_seq_ctrl_if.sv
// factorial_seq_ctrl_if: request (N) and response (N!, overflow) valid/ready channels.
interface factorial_seq_ctrl_if;
    logic                       in_valid;
    logic                       in_ready;
    logic [fact_pkg::N_W-1:0]   in_n;
    logic                       out_valid;
    logic                       out_ready;
    logic [fact_pkg::RES_W-1:0] out_fact;
    logic                       out_ovf;
    modport master (
        output in_valid, in_n, out_ready,
        input  in_ready, out_valid, out_fact, out_ovf
    );
    modport slave (
        input  in_valid, in_n, out_ready,
        output in_ready, out_valid, out_fact, out_ovf
    );
endinterface

// File: rtl/fact_mul64.sv
// fact_mul64: combinational acc x cnt truncated to the result width; done lets a
// pipelined multiplier be dropped in without touching the sequencer.
module fact_mul64 import fact_pkg::*; (
    input  logic [RES_W-1:0] a,
    input  logic [N_W-1:0]   b,
    output logic [RES_W-1:0] p,
    output logic             done
);
    assign p = a * RES_W'(b);
    assign done = 1'b1;
endmodule

// File: rtl/factorial_seq_ctrl.sv
// factorial_seq_ctrl: multi-cycle N! using one shared multiplier, one acc*cnt step per clock.
module factorial_seq_ctrl import fact_pkg::*; (
    input  logic                 clk,
    input  logic                 rst_n,
    factorial_seq_ctrl_if.slave  s,
    output logic                 busy
);
    fact_state_t      state;
    logic [RES_W-1:0] acc;
    logic [RES_W-1:0] prod;
    logic [N_W-1:0]   cnt;
    logic             ovf;
    logic             mul_done;
    logic             too_big;
    fact_mul64 u_mul (.a(acc), .b(cnt), .p(prod), .done(mul_done));
    assign too_big = s.in_n > MAX_N;
    assign s.in_ready = (state == IDLE) && rst_n;
    assign s.out_valid = state == DONE;
    assign s.out_fact = s.out_valid ? acc : '0;
    assign s.out_ovf = s.out_valid && ovf;
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (s.in_valid) begin
                    ovf   <= too_big;
                    acc   <= too_big ? '0 : FACT_ONE;
                    cnt   <= s.in_n;
                    state <= (too_big || s.in_n <= N_W'(1)) ? DONE : MULT;
                end
                // the step with cnt==2 is the last multiply; cnt==1 would be a no-op
                MULT: if (mul_done) begin
                    acc <= prod;
                    cnt <= cnt - N_W'(1);
                    if (cnt == N_W'(2)) state <= DONE;
                end
                DONE: if (s.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_factorial_seq_ctrl.sv
// tb_factorial_seq_ctrl: scoreboard bench for the sequential factorial engine.
module tb_factorial_seq_ctrl;
    typedef struct packed {
        logic [63:0] f;
        logic        o;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    factorial_seq_ctrl_if bus ();
    factorial_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .s(bus), .busy(busy));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    // response handshake happens at the next rising edge; inputs only move away from edges
    always @(negedge clk)
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) chk("sb_empty", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_fact", bus.out_fact, e.f);
                chk("out_ovf", bus.out_ovf, e.o);
            end
        end
    function automatic exp_t ref_fact(input int n);
        exp_t e;
        e.o = n > 20;
        e.f = e.o ? 64'd0 : 64'd1;
        if (!e.o) for (int i = 2; i <= n; i++) e.f = e.f * 64'(i);
        return e;
    endfunction
    task automatic accept(input logic [31:0] n, input logic [63:0] f, input logic o);
        int i;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_n = n;
        for (i = 0; i < 60 && !bus.in_ready; i++) @(negedge clk);
        chk("in_ready_wait", bus.in_ready, 1);
        sb.push_back('{f: f, o: o});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_n = $urandom;
    endtask
    task automatic wait_valid(input int k);
        int c;
        c = 0;
        while (!bus.out_valid && c < 60) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("latency", c, k);
        chk("busy_hi", busy, 1);
        chk("in_ready_done", bus.in_ready, 0);
    endtask
    task automatic finish_hs();
        @(posedge clk);
        #1;
        chk("out_valid_drop", bus.out_valid, 0);
        chk("busy_lo", busy, 0);
        chk("in_ready_back", bus.in_ready, 1);
    endtask
    task automatic run(input logic [31:0] n, input int k, input logic [63:0] f, input logic o);
        accept(n, f, o);
        wait_valid(k);
        finish_hs();
    endtask
    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
    initial begin
        exp_t e;
        int n;
        bus.in_valid = 1'b0;
        bus.in_n = '0;
        bus.out_ready = 1'b1;
        #2;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_fact", bus.out_fact, 0);
        chk("rst_out_ovf", bus.out_ovf, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        run(5, 4, 120, 0);
        run(0, 0, 1, 0);
        run(1, 0, 1, 0);
        run(2, 1, 2, 0);
        run(20, 19, 64'd2432902008176640000, 0);
        run(21, 0, 0, 1);
        run(45, 0, 0, 1);
        // stalled consumer with a competing request waiting
        bus.out_ready = 1'b0;
        accept(7, 5040, 0);
        wait_valid(6);
        bus.in_valid = 1'b1;
        bus.in_n = 3;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_fact", bus.out_fact, 5040);
            chk("stall_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        accept(3, 6, 0);
        wait_valid(2);
        finish_hs();
        // asynchronous abort in the middle of N=13
        accept(13, 64'd6227020800, 0);
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_out_fact", bus.out_fact, 0);
        chk("abort_out_ovf", bus.out_ovf, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_busy", busy, 0);
        run(13, 12, 64'd6227020800, 0);
        for (int i = 0; i < 6; i++) begin
            n = $urandom_range(0, 24);
            e = ref_fact(n);
            run(n, (n >= 2 && n <= 20) ? n - 1 : 0, e.f, e.o);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
